// File: rtl/qarctan_iter.sv
// qarctan_iter: iterative handshaked atan2(y, x), scaled by 2^BITS.
// Define QARCTAN_ITER_ROUND_EN for round-to-nearest final scaling.
module qarctan_iter #(
  parameter int          DATA_WIDTH = 32,
  parameter int          BITS       = 10,
  parameter logic [31:0] QUAD1      = 32'h324,
  parameter logic [31:0] QUAD3      = 32'h96c,
  parameter int          TAG_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int DW = DATA_WIDTH;
  localparam int IW = DW + 2;
  localparam int NW = IW + BITS;
  localparam int PW = 32 + BITS + 2;
  localparam int CW = $clog2(BITS + 1);
  localparam logic [PW-1:0] HALF =
    PW'(1) << (BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DIV,
    S_SCALE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]        x_r, y_r;
  logic [TAG_WIDTH-1:0] tag_r;
  logic [NW-1:0]        rem, den;
  logic                 neg;
  logic [CW-1:0]        cnt;
  logic [BITS:0]        q;
  logic                 ph;
  logic [PW-1:0]        pm;

  logic signed [IW-1:0] xs, ys, ay, nm, dn;
  logic signed [NW-1:0] nw;
  logic [NW-1:0]        mag, trial;
  logic                 ge;
  logic [PW-1:0]        pr;
  logic [DW-1:0]        dm, ds, ang, ang_o;

  assign in_ready = (state == S_IDLE);

  // Setup terms and the divider's trial compare.
  always_comb begin
    xs = $signed({{2{x_r[DW-1]}}, x_r});
    ys = $signed({{2{y_r[DW-1]}}, y_r});
    ay = (ys[IW-1] ? -ys : ys) + IW'(1);
    if (!xs[IW-1]) begin
      nm = xs - ay;
      dn = xs + ay;
    end else begin
      nm = xs + ay;
      dn = ay - xs;
    end
    nw    = $signed({nm, {BITS{1'b0}}});
    mag   = nw[NW-1] ? -nw : nw;
    trial = den << cnt;
    ge    = (rem >= trial);
  end

  // Final scaling: sign-magnitude divide by 2^BITS, then fold quadrant.
  always_comb begin
`ifdef QARCTAN_ITER_ROUND_EN
    pr = pm + HALF;
`else
    pr = pm;
`endif
    dm    = DW'(pr >> BITS);
    ds    = neg ? -dm : dm;
    ang   = (x_r[DW-1] ? DW'(QUAD3) : DW'(QUAD1)) - ds;
    ang_o = y_r[DW-1] ? -ang : ang;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nx = S_SETUP;
      S_SETUP: state_nx = S_DIV;
      S_DIV:   if (cnt == '0) state_nx = S_SCALE;
      S_SCALE: if (ph) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: capture, restoring divide, scale, output hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_r       <= '0;
      y_r       <= '0;
      tag_r     <= '0;
      rem       <= '0;
      den       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      q         <= '0;
      ph        <= 1'b0;
      pm        <= '0;
      dout      <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_r   <= x;
            y_r   <= y;
            tag_r <= in_tag;
          end
        end
        S_SETUP: begin
          rem <= mag;
          den <= {{BITS{1'b0}}, dn};
          neg <= nm[IW-1];
          cnt <= CW'(BITS);
          q   <= '0;
          ph  <= 1'b0;
        end
        S_DIV: begin
          if (ge) rem <= rem - trial;
          q   <= {q[BITS-1:0], ge};
          cnt <= cnt - 1'b1;
        end
        S_SCALE: begin
          ph <= 1'b1;
          if (!ph) begin
            pm <= PW'(q) * PW'(QUAD1);
          end else begin
            dout      <= ang_o;
            out_tag   <= tag_r;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qarctan_iter.sv
// tb_qarctan_iter: random + directed checks of qarctan_iter
// against an arithmetic atan2 reference model.
module tb_qarctan_iter;

  localparam int DW  = 32;
  localparam int TW  = 2;
  localparam int BITS = 10;
  localparam int LAT = BITS + 4;
  localparam longint SCL = 64'd1 << BITS;
`ifdef QARCTAN_ITER_ROUND_EN
  localparam logic [31:0] RND_EXP = 32'd537;
`else
  localparam logic [31:0] RND_EXP = 32'd538;
`endif

  logic          clock, reset;
  logic          in_valid, in_ready;
  logic          out_valid, out_ready;
  logic [DW-1:0] x, y, dout;
  logic [TW-1:0] in_tag, out_tag;

  int nchk = 0;
  int nerr = 0;

  qarctan_iter dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .out_tag  (out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_angle(
    input logic [31:0] xi, input logic [31:0] yi);
    longint xv, yv, ay, num, den, base, q, p, d, ang;
    xv = longint'($signed(xi));
    yv = longint'($signed(yi));
    ay = (yv < 0 ? -yv : yv) + 1;
    if (xv >= 0) begin
      num = (xv - ay) * SCL;
      den = xv + ay;
      base = 804;
    end else begin
      num = (xv + ay) * SCL;
      den = ay - xv;
      base = 2412;
    end
    q = (num < 0 ? -num : num) / den;
    if (num < 0) q = -q;
    p = 804 * q;
`ifdef QARCTAN_ITER_ROUND_EN
    d = ((p < 0 ? -p : p) + SCL / 2) / SCL;
    if (p < 0) d = -d;
`else
    d = p / SCL;
`endif
    ang = base - d;
    if (yv < 0) ang = -ang;
    return ang[31:0];
  endfunction

  task automatic send(input logic [31:0] xi,
                      input logic [31:0] yi,
                      input logic [1:0]  ti);
    int n;
    n = 0;
    @(negedge clock);
    x = xi;
    y = yi;
    in_tag = ti;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept", {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    in_tag = TW'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [31:0] xi,
                     input logic [31:0] yi,
                     input logic [1:0]  ti,
                     input logic [31:0] exp);
    int lat;
    send(xi, yi, ti);
    wait_out(lat);
    chk({tag, "_lat"}, lat, LAT);
    chk(tag, dout, exp);
    chk({tag, "_tag"}, {30'b0, out_tag}, {30'b0, ti});
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] xi, yi, ea, bx, by;
    int lat;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    in_tag = '0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_tag", {30'b0, out_tag}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    run("pos_x", 32'd1024, 32'd0, 2'b01, 32'd2);
    run("pos_y", 32'd0, 32'd1024, 2'b10, 32'd1608);
    run("neg_y", 32'd0, 32'hFFFFFC00, 2'b11, 32'hFFFFF9B8);
    run("neg_x", 32'hFFFFFC00, 32'd0, 2'b00, 32'd3214);
    run("diag", 32'd1000, 32'd1000, 2'b01, 32'd804);
    run("round", 32'd1024, 32'd512, 2'b10, RND_EXP);

    run("ext_nn", 32'h80000000, 32'h80000000, 2'b11,
        ref_angle(32'h80000000, 32'h80000000));
    run("ext_pn", 32'h7FFFFFFF, 32'h80000000, 2'b01,
        ref_angle(32'h7FFFFFFF, 32'h80000000));
    run("ext_np", 32'h80000000, 32'h7FFFFFFF, 2'b10,
        ref_angle(32'h80000000, 32'h7FFFFFFF));
    run("zero", 32'd0, 32'd0, 2'b00, ref_angle(32'd0, 32'd0));

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        xi = $urandom;
        yi = $urandom;
      end else begin
        xi = 32'($urandom_range(0, 8191)) - 32'd4096;
        yi = 32'($urandom_range(0, 8191)) - 32'd4096;
      end
      run("rnd", xi, yi, 2'($urandom), ref_angle(xi, yi));
    end

    ea = ref_angle(32'd300, 32'd900);
    bx = 32'd700;
    by = 32'hFFFFFF00;
    out_ready = 1'b0;
    send(32'd300, 32'd900, 2'b01);
    wait_out(lat);
    chk("bp_lat", lat, LAT);
    chk("bp_first", dout, ea);
    @(negedge clock);
    x = bx;
    y = by;
    in_tag = 2'b10;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_dout", dout, ea);
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_rel_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_rel_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clock);
    #1;
    chk("bp_taken", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    wait_out(lat);
    chk("bp2_lat", lat, LAT);
    chk("bp2_dout", dout, ref_angle(bx, by));
    chk("bp2_tag", {30'b0, out_tag}, 32'd2);
    @(posedge clock);
    #1;

    send(32'd1024, 32'd512, 2'b11);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_dout", dout, 32'd0);
    chk("mr_tag", {30'b0, out_tag}, 32'd0);
    chk("mr_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("mr_rel_ready", {31'b0, in_ready}, 32'd1);
    chk("mr_no_out", {31'b0, out_valid}, 32'd0);
    run("post_rst", 32'd1024, 32'd0, 2'b01, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
